dsp48a1_cmd_ctrl: RTL and testbench
===================================

Name: dsp48a1_cmd_ctrl

Overview:
- Initiator-side controller that drives the DSP48A1 slice's input interface and collects its results.
- Accepts operation commands over a valid/ready handshake, applies the operands and OPMODE to the slice, and tracks each command through the fixed slice pipeline with a tag shift register.
- Captures P/CARRYOUT when each command emerges and returns results in order through a buffered valid/ready result port.
- Sits between a command source (sequencer or CPU bridge) and the DSP48A1 instance.

Parameters:
- LATENCY, 4, slice cycles from DSP input sample to valid P (A/B/D regs, M reg, P reg, OPMODE reg included); legal range 1..8.
- RES_DEPTH, 4, result FIFO depth and maximum commands outstanding (in flight + buffered); power of two, 2..16.
- INIT_CYCLES, 2, cycles the DSP reset strobes are held after controller reset release.

Ports:
- clk  in  1  clock, shared with the DSP slice.
- RST  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_opmode  in  8  OPMODE for this command.
- cmd_a / cmd_b / cmd_d  in  18 each  operands.
- cmd_c  in  48  C operand.
- cmd_carryin  in  1  CARRYIN for this command.
- A, B, D  out  18 each  to slice.
- C  out  48  to slice.
- OPMODE  out  8  to slice.
- CARRYIN  out  1  to slice.
- BCIN  out  18  tied 0.
- PCIN  out  48  tied 0.
- CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN  out  1 each  clock enables.
- RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN  out  1 each  slice resets.
- P  in  48  slice result.
- CARRYOUT  in  1  slice carry out.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed on res_valid && res_ready.
- res_p  out  48  result P.
- res_carryout  out  1  result CARRYOUT.
- busy  out  1  high when any command is in flight or buffered.

Behaviour:
- Reset values while RST is high:
  - All slice RST* = 1, all CE* = 0.
  - A/B/D/C/OPMODE/CARRYIN = 0.
  - cmd_ready = 0, res_valid = 0, res_p = 0, res_carryout = 0, busy = 0.
  - Tag shift register and FIFO cleared; state = INIT.
- FSM states INIT and RUN:
  - INIT holds all slice RST* = 1 and CE* = 0 for INIT_CYCLES cycles after RST falls (counter), then moves to RUN.
  - RUN: all RST* = 0, all CE* = 1 continuously (slice never stalls).
  - No path from RUN back to INIT other than RST.
- Accept:
  - cmd_ready = (state == RUN) && (outstanding < RES_DEPTH).
  - outstanding = in-flight tags + FIFO count, held in a registered counter.
  - cmd_ready is driven from the registered counter only; a FIFO pop in the same cycle frees a credit from the next cycle.
- Issue:
  - On the accept edge, the cmd_* fields are registered onto A/B/D/C/OPMODE/CARRYIN.
  - A tag bit of 1 enters the LATENCY-deep shift register.
  - In non-accept cycles the tag is 0 and the operand outputs hold their previous values.
- Capture:
  - When the tag emerges (LATENCY cycles after the outputs change), {CARRYOUT, P} is pushed into the FIFO.
  - res_valid first rises LATENCY+1 cycles after the accept edge.
  - Back-to-back accepts give back-to-back results, in order.
- FIFO:
  - Push cannot overflow because of the credit scheme; an assertion checks push while full as an error.
  - Push and pop in the same cycle are both honoured, count unchanged.
  - res_p/res_carryout hold while res_valid && !res_ready.
- outstanding counter: +1 on accept, −1 on pop, unchanged when both occur.
- busy = (outstanding != 0).
- Reset mid-operation (RST asserted in any cycle): in-flight tags and buffered results are discarded, and the block returns to INIT.

Decomposition:
- Shared package dsp_ctrl_pkg:
  - OPMODE field constants (X_SEL_M = 2'b01, X_SEL_P, Z_SEL_C, PREADD_EN bit 4, CIN bit 5, PRE_SUB bit 6, POST_SUB bit 7).
  - Packed typedef dsp_cmd_t {opmode, a, b, d, c, carryin}.
  - Packed typedef dsp_res_t {carryout, p}.
- One sub-module: dsp_res_fifo (parameterised synchronous FIFO of dsp_res_t, RES_DEPTH entries, count output).

Test Plan:
- Reset/init: release RST → RST* stay 1 and CE* stay 0 for exactly 2 cycles; cmd_ready first rises on cycle 3 after release.
- Single multiply: opmode 8'h01, A=3, B=5, accepted at edge k → res_valid at k+5 with res_p=15, res_carryout=0; busy falls after the pop.
- Streaming: 4 back-to-back commands (opmode 8'h01, A=1..4, B=10), res_ready=1 → res_p = 10, 20, 30, 40 on consecutive cycles from k+5.
- Backpressure/credits: res_ready=0, offer 6 commands → exactly 4 accepted and cmd_ready low thereafter. Then pulse res_ready for one cycle → cmd_ready returns the following cycle; pop order is preserved.
- Pre-adder and post-add: opmode 8'h1D (pre-add, X=M, Z=C), D=7, B=2, A=4, C=100 → res_p = (7+2)*4+100 = 136.
- Reset mid-flight: accept 2 commands, assert RST 2 cycles later → no res_valid ever for them; after re-init, a new command of 8'h01 with A=2, B=2 returns res_p=4.

Source files
------------

// File: rtl/dsp_ctrl_pkg.sv
// Shared types and OPMODE field definitions for the DSP48A1 command controller.
package dsp_ctrl_pkg;

  // OPMODE[1:0]: X multiplexer select
  localparam logic [1:0] X_SEL_ZERO = 2'b00;
  localparam logic [1:0] X_SEL_M    = 2'b01;
  localparam logic [1:0] X_SEL_P    = 2'b10;
  localparam logic [1:0] X_SEL_DAB  = 2'b11;

  // OPMODE[3:2]: Z multiplexer select
  localparam logic [1:0] Z_SEL_ZERO = 2'b00;
  localparam logic [1:0] Z_SEL_PCIN = 2'b01;
  localparam logic [1:0] Z_SEL_P    = 2'b10;
  localparam logic [1:0] Z_SEL_C    = 2'b11;

  // Single-bit OPMODE fields
  localparam int PREADD_EN = 4;
  localparam int CIN       = 5;
  localparam int PRE_SUB   = 6;
  localparam int POST_SUB  = 7;

  // One command as it is applied to the slice inputs
  typedef struct packed {
    logic [7:0]  opmode;
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] d;
    logic [47:0] c;
    logic        carryin;
  } dsp_cmd_t;

  // One result as captured from the slice outputs
  typedef struct packed {
    logic        carryout;
    logic [47:0] p;
  } dsp_res_t;

  // Controller FSM: slice reset sequencing, then free-running operation
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  // Assemble an OPMODE byte from its fields
  function automatic logic [7:0] make_opmode(
    input logic [1:0] x_sel,
    input logic [1:0] z_sel,
    input logic       pre_add,
    input logic       pre_sub,
    input logic       cin_en,
    input logic       post_sub
  );
    return {post_sub, pre_sub, cin_en, pre_add, z_sel, x_sel};
  endfunction

endpackage

// File: rtl/dsp_res_fifo.sv
// Synchronous result FIFO holding dsp_res_t entries; output is zero while empty.
module dsp_res_fifo
  import dsp_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  dsp_res_t               push_data,
  input  logic                   pop,
  output dsp_res_t               pop_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  dsp_res_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            not_empty;
  logic            full;
  logic            do_pop;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign do_pop    = pop && not_empty;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head entry is presented combinationally and gated to zero when empty
  always_comb begin
    pop_data = '0;
    if (not_empty) begin
      pop_data = mem[rd_ptr_q];
    end
  end

  assign count = count_q;

  // The credit scheme upstream must never let a push land on a full FIFO
  a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/dsp48a1_cmd_ctrl.sv
// Initiator-side controller for a DSP48A1 slice: issues commands, tracks them
// through the fixed slice pipeline with tags and returns results in order.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. The initiator holds valid and its payload
// stable until the transfer; ready never depends on valid in this block, and
// res_p/res_carryout stay stable while res_valid is high and res_ready is low.
module dsp48a1_cmd_ctrl
  import dsp_ctrl_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int RES_DEPTH   = 4,
  parameter int INIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        RST,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opmode,
  input  logic [17:0] cmd_a,
  input  logic [17:0] cmd_b,
  input  logic [17:0] cmd_d,
  input  logic [47:0] cmd_c,
  input  logic        cmd_carryin,
  // slice data inputs
  output logic [17:0] A,
  output logic [17:0] B,
  output logic [17:0] D,
  output logic [47:0] C,
  output logic [7:0]  OPMODE,
  output logic        CARRYIN,
  output logic [17:0] BCIN,
  output logic [47:0] PCIN,
  // slice clock enables
  output logic        CEA,
  output logic        CEB,
  output logic        CEC,
  output logic        CED,
  output logic        CEM,
  output logic        CEP,
  output logic        CEOPMODE,
  output logic        CECARRYIN,
  // slice resets
  output logic        RSTA,
  output logic        RSTB,
  output logic        RSTC,
  output logic        RSTD,
  output logic        RSTM,
  output logic        RSTP,
  output logic        RSTOPMODE,
  output logic        RSTCARRYIN,
  // slice results
  input  logic [47:0] P,
  input  logic        CARRYOUT,
  // result port
  output logic        res_valid,
  input  logic        res_ready,
  output logic [47:0] res_p,
  output logic        res_carryout,
  output logic        busy,
  // debug view of the controller FSM
  output ctrl_state_t dbg_state
);

  localparam int OCW = $clog2(RES_DEPTH) + 1;
  localparam logic [OCW-1:0] DEPTH_CNT = OCW'(RES_DEPTH);
  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES - 1);

  ctrl_state_t          state_q;
  ctrl_state_t          state_d;
  logic [ICW-1:0]       init_cnt_q;
  logic                 slice_rst;
  logic                 slice_ce;

  dsp_cmd_t             cmd_in;
  dsp_cmd_t             issue_q;
  logic                 issue_tag_q;
  logic [LATENCY-1:0]   tag_sr_q;

  logic                 accept;
  logic                 pop;
  logic                 push;
  dsp_res_t             push_res;
  dsp_res_t             head_res;
  logic [OCW-1:0]       fifo_count;
  logic [OCW-1:0]       outstanding_q;

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------

  // State register; RST always returns the controller to INIT
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Counts the cycles the slice resets have been held since RST fell
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      init_cnt_q <= '0;
    end else if ((state_q == ST_INIT) && (init_cnt_q != INIT_LAST)) begin
      init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  // Next state and slice control: hold resets in INIT, free-run in RUN
  always_comb begin
    state_d   = state_q;
    slice_rst = 1'b1;
    slice_ce  = 1'b0;
    case (state_q)
      ST_INIT: begin
        slice_rst = 1'b1;
        slice_ce  = 1'b0;
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        slice_rst = 1'b0;
        slice_ce  = 1'b1;
        state_d   = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign dbg_state = state_q;

  assign RSTA       = slice_rst;
  assign RSTB       = slice_rst;
  assign RSTC       = slice_rst;
  assign RSTD       = slice_rst;
  assign RSTM       = slice_rst;
  assign RSTP       = slice_rst;
  assign RSTOPMODE  = slice_rst;
  assign RSTCARRYIN = slice_rst;

  assign CEA        = slice_ce;
  assign CEB        = slice_ce;
  assign CEC        = slice_ce;
  assign CED        = slice_ce;
  assign CEM        = slice_ce;
  assign CEP        = slice_ce;
  assign CEOPMODE   = slice_ce;
  assign CECARRYIN  = slice_ce;

  // ---------------------------------------------------------------------------
  // Command acceptance and issue
  // ---------------------------------------------------------------------------

  // Credits come only from the registered outstanding count, so a pop in the
  // current cycle frees a slot starting next cycle
  assign cmd_ready = (state_q == ST_RUN) && (outstanding_q < DEPTH_CNT);
  assign accept    = cmd_valid && cmd_ready;

  assign cmd_in = '{
    opmode:  cmd_opmode,
    a:       cmd_a,
    b:       cmd_b,
    d:       cmd_d,
    c:       cmd_c,
    carryin: cmd_carryin
  };

  // Operand register feeding the slice; holds between accepted commands
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      issue_q <= '0;
    end else if (accept) begin
      issue_q <= cmd_in;
    end
  end

  assign A       = issue_q.a;
  assign B       = issue_q.b;
  assign D       = issue_q.d;
  assign C       = issue_q.c;
  assign OPMODE  = issue_q.opmode;
  assign CARRYIN = issue_q.carryin;
  assign BCIN    = '0;
  assign PCIN    = '0;

  // Tag travels beside the operands: issue_tag_q marks the operand register,
  // then tag_sr_q mirrors the slice's LATENCY-cycle pipeline so the last
  // stage is high exactly while P/CARRYOUT belong to a real command
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      issue_tag_q <= 1'b0;
      tag_sr_q    <= '0;
    end else begin
      issue_tag_q <= accept;
      tag_sr_q[0] <= issue_tag_q;
      for (int i = 1; i < LATENCY; i++) begin
        tag_sr_q[i] <= tag_sr_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture and return
  // ---------------------------------------------------------------------------

  assign push           = tag_sr_q[LATENCY-1];
  assign push_res       = '{carryout: CARRYOUT, p: P};

  dsp_res_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (RST),
    .push      (push),
    .push_data (push_res),
    .pop       (pop),
    .pop_data  (head_res),
    .count     (fifo_count)
  );

  assign res_valid    = (fifo_count != '0);
  assign pop          = res_valid && res_ready;
  assign res_p        = head_res.p;
  assign res_carryout = head_res.carryout;

  // Commands in flight plus results buffered; bounds acceptance to FIFO depth
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      outstanding_q <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign busy = (outstanding_q != '0);

endmodule

// File: tb/tb_dsp48a1_cmd_ctrl.sv
// Bench for dsp48a1_cmd_ctrl: a behavioural DSP48A1 stand-in drives P/CARRYOUT,
// a scoreboard checks every returned result, plus directed timing sequences.
module tb_dsp48a1_cmd_ctrl;
  import dsp_ctrl_pkg::*;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;
  localparam int INITC = 2;
  localparam int W     = 49;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic RST;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_carryin;
  logic [7:0]  cmd_opmode;
  logic [17:0] cmd_a, cmd_b, cmd_d;
  logic [47:0] cmd_c;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN, P;
  logic [7:0]  OPMODE;
  logic        CARRYIN, CARRYOUT;
  logic CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN;
  logic RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN;
  logic        res_valid, res_ready, res_carryout, busy;
  logic [47:0] res_p;
  ctrl_state_t dbg_state;

  dsp48a1_cmd_ctrl #(
    .LATENCY     (LAT),
    .RES_DEPTH   (DEPTH),
    .INIT_CYCLES (INITC)
  ) dut (
    .clk          (clk),
    .RST          (RST),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_opmode   (cmd_opmode),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_d        (cmd_d),
    .cmd_c        (cmd_c),
    .cmd_carryin  (cmd_carryin),
    .A            (A),
    .B            (B),
    .D            (D),
    .C            (C),
    .OPMODE       (OPMODE),
    .CARRYIN      (CARRYIN),
    .BCIN         (BCIN),
    .PCIN         (PCIN),
    .CEA          (CEA),
    .CEB          (CEB),
    .CEC          (CEC),
    .CED          (CED),
    .CEM          (CEM),
    .CEP          (CEP),
    .CEOPMODE     (CEOPMODE),
    .CECARRYIN    (CECARRYIN),
    .RSTA         (RSTA),
    .RSTB         (RSTB),
    .RSTC         (RSTC),
    .RSTD         (RSTD),
    .RSTM         (RSTM),
    .RSTP         (RSTP),
    .RSTOPMODE    (RSTOPMODE),
    .RSTCARRYIN   (RSTCARRYIN),
    .P            (P),
    .CARRYOUT     (CARRYOUT),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_p        (res_p),
    .res_carryout (res_carryout),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Arithmetic model of one DSP48A1 operation (P feedback paths not used)
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] dsp_func(input logic [7:0] op, input logic [17:0] a,
                                            input logic [17:0] b, input logic [17:0] d,
                                            input logic [47:0] c, input logic cin_in);
    logic [17:0]        bp;
    logic signed [35:0] sa, sb, m;
    logic [47:0]        x, z;
    logic               cin;
    bp = b;
    if (op[4]) bp = op[6] ? (d - b) : (d + b);
    sa = 36'($signed(a));
    sb = 36'($signed(bp));
    m  = sa * sb;
    case (op[1:0])
      2'b01:   x = {{12{m[35]}}, m};
      2'b11:   x = {d[11:0], a, b};
      default: x = '0;
    endcase
    z   = (op[3:2] == 2'b11) ? c : 48'd0;
    cin = op[5] & cin_in;
    if (op[7]) return {1'b0, z} - ({1'b0, x} + {48'd0, cin});
    return {1'b0, z} + {1'b0, x} + {48'd0, cin};
  endfunction

  // Slice stand-in: samples its inputs each enabled edge, result LAT edges later
  logic [W-1:0] dsp_pipe [LAT];
  always @(posedge clk) begin
    if (RSTP) begin
      for (int i = 0; i < LAT; i++) dsp_pipe[i] <= '0;
    end else if (CEP) begin
      dsp_pipe[0] <= dsp_func(OPMODE, A, B, D, C, CARRYIN);
      for (int i = 1; i < LAT; i++) dsp_pipe[i] <= dsp_pipe[i-1];
    end
  end
  assign P        = dsp_pipe[LAT-1][47:0];
  assign CARRYOUT = dsp_pipe[LAT-1][48];

  // ---------------------------------------------------------------------------
  // Checking, scoreboard and monitors
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_acc = 0;
  int acc_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic rand_phase = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected queue filled at each accept, drained at each result transfer
  always @(posedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (RST) begin
      exp_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(dsp_func(cmd_opmode, cmd_a, cmd_b, cmd_d, cmd_c, cmd_carryin));
        n_acc++;
        acc_cyc = cyc;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got %0h expected no result", {res_carryout, res_p});
        end else begin
          e = exp_q.pop_front();
          check("sb_result", 64'({res_carryout, res_p}), 64'(e));
        end
      end
    end
  end

  // Random result backpressure during the randomized phase
  always @(negedge clk) begin
    if (rand_phase) res_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_cmd(input logic [7:0] op, input logic [17:0] a, input logic [17:0] b,
                          input logic [17:0] d, input logic [47:0] c, input logic cin);
    int start;
    start       = n_acc;
    cmd_opmode  = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_d       = d;
    cmd_c       = c;
    cmd_carryin = cin;
    cmd_valid   = 1'b1;
    for (int n = 0; n < 100 && n_acc == start; n++) @(negedge clk);
    if (n_acc == start) check("cmd_accept_timeout", 64'(n_acc - start), 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0]  op;
    logic [17:0] a, b, d;
    logic [47:0] c;
    logic        cin;
    logic [47:0] exp_p;
    logic        exp_co;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat, start, k, seen;
    logic [47:0] held;
    logic [1:0] xs, zs;

    vecs[0]  = '{8'h01, 18'd3,      18'd5,      18'd0,  48'd0,   1'b0, 48'd15,  1'b0};
    vecs[1]  = '{8'h1D, 18'd4,      18'd2,      18'd7,  48'd100, 1'b0, 48'd136, 1'b0};
    vecs[2]  = '{8'h0D, 18'd6,      18'd7,      18'd0,  48'd8,   1'b0, 48'd50,  1'b0};
    vecs[3]  = '{8'h8D, 18'd10,     18'd10,     18'd0,  48'd1000, 1'b0, 48'd900, 1'b0};
    vecs[4]  = '{8'h5D, 18'd3,      18'd5,      18'd20, 48'd5,   1'b0, 48'd50,  1'b0};
    vecs[5]  = '{8'h2D, 18'd2,      18'd2,      18'd0,  48'd0,   1'b1, 48'd5,   1'b0};
    vecs[6]  = '{8'h2C, 18'd0,      18'd0,      18'd0,  48'hFFFF_FFFF_FFFF, 1'b1, 48'd0, 1'b1};
    vecs[7]  = '{8'h01, 18'h3FFFF,  18'd5,      18'd0,  48'd0,   1'b0, 48'hFFFF_FFFF_FFFB, 1'b0};
    vecs[8]  = '{8'h03, 18'd1,      18'h12345,  18'd0,  48'd0,   1'b0, 48'h5_2345, 1'b0};
    vecs[9]  = '{8'h0C, 18'd0,      18'd0,      18'd0,  48'hAB,  1'b1, 48'hAB,  1'b0};
    vecs[10] = '{8'hAC, 18'd0,      18'd0,      18'd0,  48'd0,   1'b1, 48'hFFFF_FFFF_FFFF, 1'b1};

    // Reset state
    RST = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_opmode = '0; cmd_a = '0; cmd_b = '0; cmd_d = '0; cmd_c = '0; cmd_carryin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_slice_resets", 64'({RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTOPMODE, RSTCARRYIN}), 64'hFF);
    check("rst_slice_ce", 64'({CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN}), 64'h00);
    check("rst_abd", 64'({A, B, D}), 64'd0);
    check("rst_c_op_cin", 64'({C, OPMODE, CARRYIN}), 64'd0);
    check("rst_handshake", 64'({cmd_ready, res_valid, res_carryout, busy}), 64'd0);
    check("rst_res_p", 64'(res_p), 64'd0);
    check("tied_bcin_pcin", 64'({BCIN, PCIN} != 0), 64'd0);

    // Init sequence: two cycles of held resets, ready in the third cycle
    RST = 1'b0;
    #1;
    check("init_c1_resets", 64'({RSTA, RSTP, CEP, cmd_ready}), 64'b1100);
    @(negedge clk);
    check("init_c2_resets", 64'({RSTA, RSTP, CEP, cmd_ready}), 64'b1100);
    @(negedge clk);
    check("init_c3_resets", 64'({RSTB, RSTM, RSTOPMODE, RSTCARRYIN}), 64'd0);
    check("init_c3_ce", 64'({CEA, CEB, CEC, CED, CEM, CEP, CEOPMODE, CECARRYIN}), 64'hFF);
    check("init_c3_ready", 64'(cmd_ready), 64'd1);
    check("init_c3_state", 64'(dbg_state == ST_RUN), 64'd1);

    // Table: single commands, latency, value, hold under backpressure, busy after pop
    for (int i = 0; i < 11; i++) begin
      send_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].c, vecs[i].cin);
      for (lat = 0; lat < 20 && !res_valid; lat++) @(negedge clk);
      check("vec_latency", 64'(lat), 64'(LAT + 1));
      check("vec_p", 64'(res_p), 64'(vecs[i].exp_p));
      check("vec_carryout", 64'(res_carryout), 64'(vecs[i].exp_co));
      held = res_p;
      @(negedge clk);
      check("vec_hold", 64'({res_valid, res_p}), 64'({1'b1, held}));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("vec_busy_after_pop", 64'({busy, res_valid}), 64'd0);
    end

    // Streaming: four back-to-back commands give four back-to-back results
    res_ready = 1'b1;
    send_cmd(8'h01, 18'd1, 18'd10, 18'd0, 48'd0, 1'b0);
    k = acc_cyc;
    for (int i = 2; i <= 4; i++) send_cmd(8'h01, 18'(i), 18'd10, 18'd0, 48'd0, 1'b0);
    check("stream_accept_spacing", 64'(acc_cyc - k), 64'd3);
    while (cyc < k + LAT + 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", 64'(res_valid), 64'd1);
      check("stream_p", 64'(res_p), 64'(10 * (i + 1)));
      @(negedge clk);
    end
    check("stream_end_valid", 64'(res_valid), 64'd0);
    res_ready = 1'b0;

    // Backpressure: credits stop acceptance at DEPTH outstanding
    start = n_acc;
    cmd_opmode = 8'h01; cmd_b = 18'd3; cmd_a = 18'd1; cmd_d = '0; cmd_c = '0; cmd_carryin = 1'b0;
    cmd_valid = 1'b1;
    repeat (12) begin
      @(negedge clk);
      cmd_a = 18'(n_acc - start + 1);
    end
    check("bp_accepted", 64'(n_acc - start), 64'(DEPTH));
    check("bp_ready_low", 64'({cmd_ready, busy}), 64'b01);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_credit_return", 64'(cmd_ready), 64'd1);
    check("bp_not_yet_accepted", 64'(n_acc - start), 64'(DEPTH));
    @(negedge clk);
    check("bp_fifth_accepted", 64'(n_acc - start), 64'(DEPTH + 1));
    check("bp_ready_low_again", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle();
    res_ready = 1'b0;

    // Reset mid-flight: in-flight commands are discarded
    send_cmd(8'h01, 18'd7, 18'd7, 18'd0, 48'd0, 1'b0);
    send_cmd(8'h01, 18'd8, 18'd8, 18'd0, 48'd0, 1'b0);
    repeat (2) @(negedge clk);
    RST = 1'b1;
    #1;
    check("midrst_cleared", 64'({busy, res_valid, cmd_ready, RSTP, CEP}), 64'b00010);
    @(negedge clk);
    RST = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("midrst_no_stale_result", 64'(seen), 64'd0);
    res_ready = 1'b0;
    send_cmd(8'h01, 18'd2, 18'd2, 18'd0, 48'd0, 1'b0);
    for (lat = 0; lat < 20 && !res_valid; lat++) @(negedge clk);
    check("midrst_new_latency", 64'(lat), 64'(LAT + 1));
    check("midrst_new_p", 64'(res_p), 64'd4);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Randomized commands with random gaps and random result backpressure
    rand_phase = 1'b1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xs = 2'($urandom_range(0, 2));
      if (xs == 2'b10) xs = X_SEL_DAB;
      zs = 2'($urandom_range(0, 2));
      if (zs == 2'b10) zs = Z_SEL_C;
      send_cmd(make_opmode(xs, zs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
               18'($urandom), 18'($urandom), 18'($urandom),
               {16'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
    end
    rand_phase = 1'b0;
    @(negedge clk);
    res_ready = 1'b1;
    wait_idle();
    res_ready = 1'b0;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
